axi3_hp_burst_reader: RTL and testbench
=======================================

AXI3_HP_BURST_READER -- requirements
Module: axi3_hp_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning AXI read data width in bits (32 or 64).
REQ-002 SHALL have parameter BURST_LEN, default 16, meaning beats per AXI3 burst (1..16).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum issued-but-incomplete bursts (1..8).
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the burst-count input.
REQ-005 SHALL use one clock and a synchronous, active-low reset; ports: CLK input 1, DMA and AXI clock; RESETN input 1, synchronous active-low reset.
REQ-006 SHALL have ports: DMA_RD_ADDR input 32, byte start address aligned to BURST_LEN*DATA_WIDTH/8; DMA_BURST_COUNT input COUNT_WIDTH, bursts to read; DMA_START input 1, start pulse.
REQ-007 SHALL have ports: DMA_READY output 1, idle; DMA_DONE output 1, one-cycle completion pulse; DMA_ERROR output 1, sticky error flag.
REQ-008 SHALL have ports: DMA_RD_DATA output DATA_WIDTH, data; DMA_RD_DATA_VALID output 1, data valid; DMA_RD_DATA_READY input 1, sink ready.
REQ-009 SHALL have AXI3 AR ports: m00_axi_arready input 1; m00_axi_araddr output 32; m00_axi_arlen output 4; m00_axi_arsize output 3; m00_axi_arburst output 2; m00_axi_arvalid output 1.
REQ-010 SHALL have AXI3 R ports: m00_axi_rdata input DATA_WIDTH; m00_axi_rresp input 2; m00_axi_rlast input 1; m00_axi_rvalid input 1; m00_axi_rready output 1.

Function
REQ-011 SHALL implement states IDLE, ISSUE, DRAIN; IDLE->ISSUE on DMA_START&DMA_READY with DMA_BURST_COUNT>0; ISSUE->DRAIN on the last AR handshake; DRAIN->IDLE when outstanding count reaches 0.
REQ-012 SHALL, on accepted DMA_START with DMA_BURST_COUNT=0, stay IDLE, pulse DMA_DONE the next cycle, and issue no AXI traffic.
REQ-013 SHALL ignore DMA_START while DMA_READY=0.
REQ-014 SHALL drive constant arlen=BURST_LEN-1, arsize=log2(DATA_WIDTH/8), arburst=2'b01 (INCR).
REQ-015 SHALL present burst k at araddr=DMA_RD_ADDR+k*BURST_LEN*DATA_WIDTH/8, 32-bit wrap-around, k=0..DMA_BURST_COUNT-1.
REQ-016 SHALL assert arvalid the cycle after start; SHALL hold araddr/arvalid stable until arready; SHALL assert arvalid only while outstanding<MAX_OUTSTANDING.
REQ-017 SHALL keep an outstanding counter: +1 on AR handshake; -1 on R handshake with rlast; unchanged when both occur in the same cycle.
REQ-018 SHALL drive rready=DMA_RD_DATA_READY when not IDLE, else 0; DMA_RD_DATA=rdata and DMA_RD_DATA_VALID=rvalid&~IDLE, combinationally (zero latency).
REQ-019 SHALL, in the cycle after the final rlast handshake, pulse DMA_DONE for one cycle and set DMA_READY=1 in the same cycle.

Reset
REQ-020 SHALL, on RESETN=0 at a CLK edge, enter IDLE with DMA_READY=1, DMA_DONE=0, DMA_ERROR=0, arvalid=0, rready=0, and all counters 0.
REQ-021 SHALL, on reset mid-operation, abandon in-flight bursts without tracking them; interconnect reset is the system's responsibility.

Configuration
REQ-022 SHALL, with AXI3_HP_READER_RRESP_CHECK_EN defined, set DMA_ERROR on any R handshake with rresp!=2'b00, holding it until the next accepted DMA_START or reset; transfer still completes normally.
REQ-023 SHALL, without AXI3_HP_READER_RRESP_CHECK_EN, tie DMA_ERROR to 0 and ignore m00_axi_rresp.

Structure
REQ-024 SHALL take the state enum, AXI constants (INCR burst encoding, OKAY response), and the arsize helper function from shared package axi3_hp_pkg.
REQ-025 SHALL place the outstanding counter with its up/down/limit logic in sub-module axi3_hp_outstanding_ctr.

Verification
REQ-026 SHALL verify: DATA_WIDTH=64, BURST_LEN=16, addr 0x1000, count 3 -> araddr 0x1000/0x1080/0x1100, 48 data beats, one DMA_DONE.
REQ-027 SHALL verify: MAX_OUTSTANDING=2, slave withholds R data -> third arvalid held low until first rlast handshake.
REQ-028 SHALL verify: DMA_RD_DATA_READY low 5 cycles mid-burst -> rready low for exactly those cycles; no beat lost or duplicated.
REQ-029 SHALL verify: count 0 -> DMA_DONE one cycle after start, arvalid never asserted.
REQ-030 SHALL verify: rresp=2'b10 on one beat with macro -> DMA_ERROR=1 until next start; without macro -> DMA_ERROR stays 0.
REQ-031 SHALL verify: RESETN low during DRAIN -> next cycle DMA_READY=1, arvalid=0, rready=0.

Source files
------------

// File: rtl/axi3_hp_pkg.sv
// Shared types and AXI3 constants for the HP burst reader.
package axi3_hp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(
    input int unsigned bytes
  );
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi3_hp_burst_reader_if.sv
// AXI3 read-address and read-data channels of the HP port.
interface axi3_hp_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic                  m00_axi_arready;
  logic [31:0]           m00_axi_araddr;
  logic [3:0]            m00_axi_arlen;
  logic [2:0]            m00_axi_arsize;
  logic [1:0]            m00_axi_arburst;
  logic                  m00_axi_arvalid;
  logic [DATA_WIDTH-1:0] m00_axi_rdata;
  logic [1:0]            m00_axi_rresp;
  logic                  m00_axi_rlast;
  logic                  m00_axi_rvalid;
  logic                  m00_axi_rready;

  modport master (
    input  m00_axi_arready,
    output m00_axi_araddr,
    output m00_axi_arlen,
    output m00_axi_arsize,
    output m00_axi_arburst,
    output m00_axi_arvalid,
    input  m00_axi_rdata,
    input  m00_axi_rresp,
    input  m00_axi_rlast,
    input  m00_axi_rvalid,
    output m00_axi_rready
  );

  modport slave (
    output m00_axi_arready,
    input  m00_axi_araddr,
    input  m00_axi_arlen,
    input  m00_axi_arsize,
    input  m00_axi_arburst,
    input  m00_axi_arvalid,
    output m00_axi_rdata,
    output m00_axi_rresp,
    output m00_axi_rlast,
    output m00_axi_rvalid,
    input  m00_axi_rready
  );

endinterface

// File: rtl/axi3_hp_outstanding_ctr.sv
// Up/down count of issued-but-incomplete bursts with issue limit.
module axi3_hp_outstanding_ctr #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic can_issue_o,
  output logic last_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign can_issue_o = cnt_q < MAX_C;
  assign last_o      = cnt_q == CW'(1);

endmodule

// File: rtl/axi3_hp_burst_reader.sv
// DMA-driven AXI3 INCR burst reader for an HP port.
// Define AXI3_HP_READER_RRESP_CHECK_EN to flag non-OKAY read responses.
module axi3_hp_burst_reader
  import axi3_hp_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic [31:0]            DMA_RD_ADDR,
  input  logic [COUNT_WIDTH-1:0] DMA_BURST_COUNT,
  input  logic                   DMA_START,
  output logic                   DMA_READY,
  output logic                   DMA_DONE,
  output logic                   DMA_ERROR,
  output logic [DATA_WIDTH-1:0]  DMA_RD_DATA,
  output logic                   DMA_RD_DATA_VALID,
  input  logic                   DMA_RD_DATA_READY,
  axi3_hp_if.master              axi
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [31:0] BURST_BYTES =
    32'(BURST_LEN * BEAT_BYTES);

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] left_q, left_d;
  logic                   done_q, done_d;

  logic idle;
  logic ar_hs;
  logic r_hs;
  logic rlast_hs;
  logic can_issue;
  logic last_out;

  assign idle     = state_q == ST_IDLE;
  assign ar_hs    = axi.m00_axi_arvalid
                  & axi.m00_axi_arready;
  assign r_hs     = axi.m00_axi_rvalid
                  & axi.m00_axi_rready;
  assign rlast_hs = r_hs & axi.m00_axi_rlast;

  axi3_hp_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ctr (
    .clk_i       (CLK),
    .rst_ni      (RESETN),
    .inc_i       (ar_hs),
    .dec_i       (rlast_hs),
    .can_issue_o (can_issue),
    .last_o      (last_out)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (DMA_START) begin
          if (DMA_BURST_COUNT == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            addr_d  = DMA_RD_ADDR;
            left_d  = DMA_BURST_COUNT;
          end
        end
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          addr_d = addr_q + BURST_BYTES;
          left_d = left_q - COUNT_WIDTH'(1);
          if (left_q == COUNT_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Only reads remain, so one outstanding + rlast means finished
        if (rlast_hs && last_out) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

`ifdef AXI3_HP_READER_RRESP_CHECK_EN
  logic err_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      err_q <= 1'b0;
    end else if (idle && DMA_START) begin
      err_q <= 1'b0;
    end else if (r_hs &&
                 axi.m00_axi_rresp != AXI_RESP_OKAY) begin
      err_q <= 1'b1;
    end
  end

  assign DMA_ERROR = err_q;
`else
  assign DMA_ERROR = 1'b0;
`endif

  // Address stays put while waiting: no AR handshake means no +1
  assign axi.m00_axi_arvalid = (state_q == ST_ISSUE)
                             & can_issue;
  assign axi.m00_axi_araddr  = addr_q;
  assign axi.m00_axi_arlen   = 4'(BURST_LEN - 1);
  assign axi.m00_axi_arsize  = axi_size(BEAT_BYTES);
  assign axi.m00_axi_arburst = AXI_BURST_INCR;
  assign axi.m00_axi_rready  = ~idle & DMA_RD_DATA_READY;

  assign DMA_RD_DATA       = axi.m00_axi_rdata;
  assign DMA_RD_DATA_VALID = axi.m00_axi_rvalid & ~idle;
  assign DMA_READY         = idle;
  assign DMA_DONE          = done_q;

endmodule

// File: tb/tb_axi3_hp_burst_reader.sv
// Directed bench for axi3_hp_burst_reader with a simple AXI3 slave.
module tb_axi3_hp_burst_reader;

  localparam int DW = 64;
  localparam int BL = 16;
`ifdef AXI3_HP_READER_RRESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   addr;
  logic [15:0]   cnt;
  logic          start;
  logic          rdy_o;
  logic          done;
  logic          err;
  logic [DW-1:0] data;
  logic          dval;
  logic          drdy;

  logic ar_en;
  logic r_en;
  int   err_idx = -1;
  int   gbeat = 0;
  int   beat = 0;
  int   done_cnt = 0;
  int   arv_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0]   arq[$];
  logic [31:0]   ar_log[$];
  logic [DW-1:0] got[$];

  axi3_hp_if #(.DATA_WIDTH(DW)) axi_if ();

  axi3_hp_burst_reader #(
    .DATA_WIDTH      (DW),
    .BURST_LEN       (BL),
    .MAX_OUTSTANDING (2),
    .COUNT_WIDTH     (16)
  ) dut (
    .CLK               (clk),
    .RESETN            (rstn),
    .DMA_RD_ADDR       (addr),
    .DMA_BURST_COUNT   (cnt),
    .DMA_START         (start),
    .DMA_READY         (rdy_o),
    .DMA_DONE          (done),
    .DMA_ERROR         (err),
    .DMA_RD_DATA       (data),
    .DMA_RD_DATA_VALID (dval),
    .DMA_RD_DATA_READY (drdy),
    .axi               (axi_if.master)
  );

  always #5 clk = ~clk;

  assign axi_if.m00_axi_arready = ar_en;

  always @(posedge clk) begin
    if (!rstn) begin
      arq.delete();
      beat = 0;
      axi_if.m00_axi_rvalid <= 1'b0;
      axi_if.m00_axi_rlast  <= 1'b0;
      axi_if.m00_axi_rdata  <= '0;
      axi_if.m00_axi_rresp  <= 2'b00;
    end else begin
      if (axi_if.m00_axi_arvalid &&
          axi_if.m00_axi_arready) begin
        arq.push_back(axi_if.m00_axi_araddr);
        ar_log.push_back(axi_if.m00_axi_araddr);
      end
      if (axi_if.m00_axi_rvalid &&
          axi_if.m00_axi_rready) begin
        gbeat++;
        if (axi_if.m00_axi_rlast) begin
          void'(arq.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
      if (r_en && arq.size() != 0) begin
        axi_if.m00_axi_rvalid <= 1'b1;
        axi_if.m00_axi_rdata  <= {arq[0], 32'(beat)};
        axi_if.m00_axi_rlast  <= (beat == BL - 1);
        axi_if.m00_axi_rresp  <=
          (gbeat == err_idx) ? 2'b10 : 2'b00;
      end else begin
        axi_if.m00_axi_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (dval && drdy) got.push_back(data);
    if (done) done_cnt++;
    if (axi_if.m00_axi_arvalid) arv_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(input logic [31:0] a,
                      input logic [15:0] c);
    addr  = a;
    cnt   = c;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      step(1);
      n++;
    end
    check(tag, {63'd0, done}, 64'd1);
  endtask

  task automatic check_data(input string tag,
                            input int g0,
                            input int n,
                            input logic [31:0] base);
    int bad = 0;
    logic [63:0] exp;
    check({tag, "_beats"}, 64'(got.size() - g0),
          64'(n));
    for (int j = 0; j < n && g0 + j < got.size(); j++) begin
      exp = {base + 32'((j / BL) * BL * 8),
             32'(j % BL)};
      if (got[g0 + j] !== exp) bad++;
    end
    check({tag, "_data"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int a0;
    int g0;
    int d0;
    int v0;
    int n;
    rstn  = 1'b0;
    addr  = '0;
    cnt   = '0;
    start = 1'b0;
    drdy  = 1'b1;
    ar_en = 1'b1;
    r_en  = 1'b1;
    step(3);
    check("rst_ready", {63'd0, rdy_o}, 64'd1);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_arvalid",
          {63'd0, axi_if.m00_axi_arvalid}, 64'd0);
    check("rst_rready",
          {63'd0, axi_if.m00_axi_rready}, 64'd0);
    rstn = 1'b1;
    step(2);

    // three bursts from 0x1000
    a0 = ar_log.size();
    g0 = got.size();
    d0 = done_cnt;
    kick(32'h1000, 16'd3);
    check("t1_busy", {63'd0, rdy_o}, 64'd0);
    check("t1_arvalid",
          {63'd0, axi_if.m00_axi_arvalid}, 64'd1);
    check("t1_arlen",
          {60'd0, axi_if.m00_axi_arlen}, 64'd15);
    check("t1_arsize",
          {61'd0, axi_if.m00_axi_arsize}, 64'd3);
    check("t1_arburst",
          {62'd0, axi_if.m00_axi_arburst}, 64'd1);
    wait_done("t1_done", 500);
    check("t1_ready_w_done", {63'd0, rdy_o}, 64'd1);
    step(3);
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_ar_cnt", 64'(ar_log.size() - a0), 64'd3);
    if (ar_log.size() - a0 >= 3) begin
      check("t1_ar0", {32'd0, ar_log[a0]}, 64'h1000);
      check("t1_ar1", {32'd0, ar_log[a0 + 1]}, 64'h1080);
      check("t1_ar2", {32'd0, ar_log[a0 + 2]}, 64'h1100);
    end
    check_data("t1", g0, 48, 32'h1000);

    // limit of two outstanding while R is withheld
    a0 = ar_log.size();
    g0 = got.size();
    r_en = 1'b0;
    kick(32'h2000, 16'd3);
    step(10);
    check("t2_ar_held", 64'(ar_log.size() - a0), 64'd2);
    check("t2_arvalid_low",
          {63'd0, axi_if.m00_axi_arvalid}, 64'd0);
    r_en = 1'b1;
    n = 0;
    while (ar_log.size() - a0 < 3 && n < 200) begin
      step(1);
      n++;
    end
    check("t2_ar3_after_rlast",
          {63'd0, got.size() - g0 >= BL}, 64'd1);
    wait_done("t2_done", 500);
    step(2);
    check_data("t2", g0, 48, 32'h2000);

    // sink stalls for five cycles mid-burst
    g0 = got.size();
    kick(32'h3000, 16'd1);
    n = 0;
    while (got.size() - g0 < 5 && n < 100) begin
      step(1);
      n++;
    end
    drdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("t3_rready_low%0d", i),
            {63'd0, axi_if.m00_axi_rready}, 64'd0);
      @(posedge clk);
      #1;
    end
    drdy = 1'b1;
    #2;
    check("t3_rready_back",
          {63'd0, axi_if.m00_axi_rready}, 64'd1);
    step(1);
    wait_done("t3_done", 300);
    step(2);
    check_data("t3", g0, 16, 32'h3000);

    // zero-count start
    v0 = arv_cnt;
    kick(32'h7000, 16'd0);
    check("t4_done", {63'd0, done}, 64'd1);
    check("t4_ready", {63'd0, rdy_o}, 64'd1);
    step(1);
    check("t4_done_pulse", {63'd0, done}, 64'd0);
    step(3);
    check("t4_no_arvalid", 64'(arv_cnt - v0), 64'd0);

    // error response on one beat
    g0 = got.size();
    err_idx = gbeat + 5;
    kick(32'h4000, 16'd1);
    wait_done("t5_done", 300);
    step(1);
    check("t5_err", {63'd0, err}, {63'd0, EXP_ERR});
    step(4);
    check("t5_err_sticky", {63'd0, err}, {63'd0, EXP_ERR});
    check_data("t5", g0, 16, 32'h4000);
    kick(32'h0, 16'd0);
    check("t5_err_clr", {63'd0, err}, 64'd0);
    step(2);

    // reset while draining
    a0 = ar_log.size();
    r_en = 1'b0;
    kick(32'h5000, 16'd2);
    step(6);
    check("t6_in_drain", {63'd0, rdy_o}, 64'd0);
    check("t6_ar_cnt", 64'(ar_log.size() - a0), 64'd2);
    rstn = 1'b0;
    step(1);
    check("t6_ready", {63'd0, rdy_o}, 64'd1);
    check("t6_arvalid",
          {63'd0, axi_if.m00_axi_arvalid}, 64'd0);
    check("t6_rready",
          {63'd0, axi_if.m00_axi_rready}, 64'd0);
    check("t6_done", {63'd0, done}, 64'd0);
    rstn = 1'b1;
    r_en = 1'b1;
    step(2);
    g0 = got.size();
    kick(32'h6000, 16'd1);
    wait_done("t6_recover", 300);
    step(2);
    check_data("t6", g0, 16, 32'h6000);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
